instruction_fetch_unit: RTL and testbench

IF stage of the pipelined LEGv8 core. It owns the PC, drives the instruction-memory address, and registers the returned 32-bit word into the IF/ID pipeline register. It accepts stall and branch-redirect requests from later stages. It replaces flushed or idle slots with the canonical NOP (ADD XZR,XZR,XZR = 32'h8B1F03FF).

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 56 +++++
 rtl/instruction_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and FSM encoding for the LEGv8 instruction fetch unit.
package ifu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 64;

    // ADD XZR, XZR, XZR: the canonical bubble.
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h8B1F03FF;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } ifu_state_e;

    // Force word alignment of a redirect address.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: pc/instr/valid with flush (highest priority), load and hold.
// Reset and flush both load the bubble value {pc=0, RESET_INSTR, valid=0}.
module if_id_reg
    import ifu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_INSTR = NOP_WORD
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [ADDR_W-1:0]  pc_d, pc_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic               valid_d, valid_q;

    // Next-state select: flush beats load, otherwise hold.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = '0;
            instr_d = RESET_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    // Pipeline register state, asynchronously reset to a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            instr_q <= RESET_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage of the pipelined LEGv8 core: PC, BOOT/RUN/DONE sequencing, branch redirect and
// IF/ID register. Optional build macro IFU_PERF_CNT_EN adds saturating fetch/bubble counters.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC = 64'h0,
    parameter logic [ADDR_W-1:0]  PC_LIMIT = 64'h100,
    parameter logic [INSTR_W-1:0] NOP_WORD = ifu_pkg::NOP_WORD
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic [ADDR_W-1:0]  if_pc_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic               if_valid_o,
    output logic               misalign_o,
    output logic               done_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        bubble_cnt_o
`endif
);

    ifu_state_e        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              done_q;
    logic              misalign_q;
    logic              ifid_load;
    logic              ifid_flush;
    logic [ADDR_W-1:0] target_aligned;
    logic              target_misaligned;
    logic              past_limit;

    assign target_aligned    = align_word(branch_target_i);
    assign target_misaligned = (branch_target_i[1:0] != 2'b00);
    assign past_limit        = (pc_q > PC_LIMIT);

    // IF/ID control: capture on a normal fetch, bubble on BOOT, flush, limit overrun and DONE.
    always_comb begin
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            StRun: begin
                if (branch_taken_i) begin
                    ifid_flush = 1'b1;
                end else if (!stall_i) begin
                    if (past_limit) ifid_flush = 1'b1;
                    else            ifid_load  = 1'b1;
                end
            end
            default: ifid_flush = 1'b1;
        endcase
    end

    // Fetch FSM with PC, done and sticky misalign flags as registered outputs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            unique case (state_q)
                StBoot: state_q <= StRun;
                StRun: begin
                    if (branch_taken_i) begin
                        pc_q <= target_aligned;
                        if (target_misaligned) misalign_q <= 1'b1;
                    end else if (!stall_i) begin
                        if (past_limit) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q <= pc_q + 64'd4;
                        end
                    end
                end
                StDone: begin
                    // stall_i is deliberately ignored here.
                    if (branch_taken_i) begin
                        pc_q <= target_aligned;
                        if (target_misaligned) misalign_q <= 1'b1;
                        if (target_aligned <= PC_LIMIT) begin
                            state_q <= StRun;
                            done_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    if_id_reg #(
        .RESET_INSTR(NOP_WORD)
    ) u_if_id_reg (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .pc_i    (pc_q),
        .instr_i (imem_instr_i),
        .pc_o    (if_pc_o),
        .instr_o (if_instr_o),
        .valid_o (if_valid_o)
    );

    assign imem_addr_o = pc_q;
    assign misalign_o  = misalign_q;
    assign done_o      = done_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Saturating counters of real captures and bubble loads (stall cycles load neither).
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (ifid_load && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (ifid_flush && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with an address-tagged instruction ROM.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h8B1F03FF;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        misalign;
    logic        done;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return {8'hE0, a[23:0]};
    endfunction

    assign imem_instr = rom_word(imem_addr);

    instruction_fetch_unit #(
        .RESET_PC (64'h0),
        .PC_LIMIT (64'h100),
        .NOP_WORD (32'h8B1F03FF)
    ) dut (
        .CLK             (clk),
        .Reset           (rst),
        .stall_i         (stall),
        .branch_taken_i  (br_taken),
        .branch_target_i (br_target),
        .imem_addr_o     (imem_addr),
        .imem_instr_i    (imem_instr),
        .if_pc_o         (if_pc),
        .if_instr_o      (if_instr),
        .if_valid_o      (if_valid),
        .misalign_o      (misalign),
        .done_o          (done)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt_o     (fetch_cnt),
        .bubble_cnt_o    (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [63:0] pc,
                              input logic [31:0] instr, input logic valid);
        check_eq({tag, "_pc"}, if_pc, pc);
        check_eq({tag, "_instr"}, {32'h0, if_instr}, {32'h0, instr});
        check_eq({tag, "_valid"}, {63'h0, if_valid}, {63'h0, valid});
    endtask

    task automatic check_reset_vals(input string tag);
        check_ifid(tag, 64'h0, NOP, 1'b0);
        check_eq({tag, "_addr"}, imem_addr, 64'h0);
        check_eq({tag, "_done"}, {63'h0, done}, 64'h0);
        check_eq({tag, "_misal"}, {63'h0, misalign}, 64'h0);
    endtask

    // Free-run until the PC reaches target, within a cycle budget.
    task automatic run_until(input string tag, input logic [63:0] target, input int max);
        for (int i = 0; i < max; i++) begin
            if (imem_addr == target) break;
            step();
        end
        check_eq({tag, "_reach"}, imem_addr, target);
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 64'h0;
        #2;
        check_reset_vals("rst");
        rst = 1'b0;

        // 1: BOOT bubble, then sequential captures 0, 4, 8
        step();
        check_ifid("boot", 64'h0, NOP, 1'b0);
        check_eq("boot_addr", imem_addr, 64'h0);
        step();
        check_ifid("f0", 64'h0, 32'hE000_0000, 1'b1);
        step();
        check_ifid("f4", 64'h4, 32'hE000_0004, 1'b1);
        step();
        check_ifid("f8", 64'h8, 32'hE000_0008, 1'b1);
        check_eq("f8_addr", imem_addr, 64'hC);
`ifdef IFU_PERF_CNT_EN
        check_eq("perf_fetch", {32'h0, fetch_cnt}, 64'd3);
        check_eq("perf_bubble", {32'h0, bubble_cnt}, 64'd1);
`endif

        // 2: stall for 3 cycles at PC=0x10
        step();
        check_eq("pre_stall_addr", imem_addr, 64'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_addr", imem_addr, 64'h10);
            check_ifid("stall", 64'hC, 32'hE000_000C, 1'b1);
        end
        stall = 1'b0;
        step();
        check_ifid("unstall", 64'h10, 32'hE000_0010, 1'b1);

        // 3: branch overrides stall
        run_until("to48", 64'h48, 40);
        br_taken  = 1'b1;
        br_target = 64'h54;
        stall     = 1'b1;
        step();
        br_taken = 1'b0;
        stall    = 1'b0;
        check_ifid("br54", 64'h0, NOP, 1'b0);
        check_eq("br54_addr", imem_addr, 64'h54);
        step();
        check_ifid("tgt54", 64'h54, 32'hE000_0054, 1'b1);

        // 4: misaligned target, sticky flag
        br_taken  = 1'b1;
        br_target = 64'h3E;
        step();
        br_taken = 1'b0;
        check_eq("mis_addr", imem_addr, 64'h3C);
        check_eq("mis_flag", {63'h0, misalign}, 64'h1);
        step();
        check_ifid("tgt3c", 64'h3C, 32'hE000_003C, 1'b1);
        step();
        step();
        check_eq("mis_sticky", {63'h0, misalign}, 64'h1);

        // 5: run past PC_LIMIT into DONE
        run_until("to100", 64'h100, 80);
        check_eq("pre_lim_done", {63'h0, done}, 64'h0);
        step();
        check_ifid("lim100", 64'h100, 32'hE000_0100, 1'b1);
        check_eq("lim_addr", imem_addr, 64'h104);
        step();
        check_ifid("over", 64'h0, NOP, 1'b0);
        check_eq("over_done", {63'h0, done}, 64'h1);
        check_eq("over_addr", imem_addr, 64'h104);
        stall = 1'b1;
        step();
        stall = 1'b0;
        check_eq("done_frozen", imem_addr, 64'h104);
        check_eq("done_hold", {63'h0, done}, 64'h1);
        br_taken  = 1'b1;
        br_target = 64'h200;
        step();
        check_eq("far_done", {63'h0, done}, 64'h1);
        check_eq("far_addr", imem_addr, 64'h200);
        br_target = 64'h6C;
        step();
        br_taken = 1'b0;
        check_eq("back_done", {63'h0, done}, 64'h0);
        check_eq("back_addr", imem_addr, 64'h6C);
        check_ifid("back_flush", 64'h0, NOP, 1'b0);
        step();
        check_ifid("tgt6c", 64'h6C, 32'hE000_006C, 1'b1);

        // 6: asynchronous reset mid-cycle, then BOOT again
        step();
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("arst");
        #2;
        rst = 1'b0;
        step();
        check_ifid("reboot", 64'h0, NOP, 1'b0);
        step();
        check_ifid("re_f0", 64'h0, 32'hE000_0000, 1'b1);
        step();
        step();
        check_ifid("re_f8", 64'h8, 32'hE000_0008, 1'b1);
`ifdef IFU_PERF_CNT_EN
        check_eq("re_perf_fetch", {32'h0, fetch_cnt}, 64'd3);
        check_eq("re_perf_bubble", {32'h0, bubble_cnt}, 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
